// File: rtl/output_send_seq_if.sv
// Bus bundle between the conv-core controller and the output write sequencer.
// WSTRIDE_I exists only when OSEND_STRIDE_EN is defined.
interface output_send_seq_if #(
  parameter int unsigned AW  = 16,
  parameter int unsigned CW  = 8,
  parameter int unsigned NCH = 6
);
  logic           OUTPUT_SEND;
  logic           OUTPUT_SEND_POOL;
  logic [CW-1:0]  COUNTER0;
  logic [AW-1:0]  WADDRX_I;
  logic [NCH-1:0] OUTPUT_EN_CTRL_I;
  logic           module_busy;
`ifdef OSEND_STRIDE_EN
  logic [AW-1:0]  WSTRIDE_I;
`endif
  logic [AW-1:0]  WADDRX;
  logic           WCEBX;
  logic           OUTPUT_EN;
  logic [NCH-1:0] OUTPUT_EN_CTRL;
  logic           O_COMPARE_EN;
  logic           O_COMPARE_MODE;
  logic           O_COMPARE_SWITCH;
  logic           OUTPUT_BUSY;
  logic           OUTPUT_DONE;

  modport master (
`ifdef OSEND_STRIDE_EN
    output WSTRIDE_I,
`endif
    output OUTPUT_SEND, OUTPUT_SEND_POOL, COUNTER0, WADDRX_I, OUTPUT_EN_CTRL_I, module_busy,
    input  WADDRX, WCEBX, OUTPUT_EN, OUTPUT_EN_CTRL, O_COMPARE_EN, O_COMPARE_MODE,
    input  O_COMPARE_SWITCH, OUTPUT_BUSY, OUTPUT_DONE
  );

  modport slave (
`ifdef OSEND_STRIDE_EN
    input  WSTRIDE_I,
`endif
    input  OUTPUT_SEND, OUTPUT_SEND_POOL, COUNTER0, WADDRX_I, OUTPUT_EN_CTRL_I, module_busy,
    output WADDRX, WCEBX, OUTPUT_EN, OUTPUT_EN_CTRL, O_COMPARE_EN, O_COMPARE_MODE,
    output O_COMPARE_SWITCH, OUTPUT_BUSY, OUTPUT_DONE
  );
endinterface

// File: rtl/output_send_seq.sv
// Output SRAM write sequencer for the conv core, no-pool and pooled transfers.
// Optional OSEND_STRIDE_EN adds a programmable address stride (default stride 1).
module output_send_seq #(
  parameter int unsigned AW       = 16,
  parameter int unsigned CW       = 8,
  parameter int unsigned NCH      = 6,
  parameter int unsigned POOL_K   = 4,
  parameter bit          POOL_MAX = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTL,
  output_send_seq_if.slave  bus
);
  localparam int unsigned KW = $clog2(POOL_K + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_CMP, S_WR, S_DONE} state_e;

  state_e         state_q, state_d;
  logic           pool_q, pool_d;
  logic [CW-1:0]  cnt_max_q, cnt_max_d;
  logic [CW-1:0]  wcnt_q, wcnt_d;
  logic [KW-1:0]  kcnt_q, kcnt_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] ctrl_q, ctrl_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [AW-1:0]  waddr_q, waddr_d;
  logic           wceb_q, wceb_d;
  logic           oen_q, oen_d;
  logic           cmp_en_q, cmp_en_d;
  logic           cmp_mode_q, cmp_mode_d;
  logic           cmp_sw_q, cmp_sw_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [NCH-1:0] sel_c;
  logic [AW-1:0]  stride_c;
  logic           do_wr, do_cmp, cmp_first, stalled;

`ifdef OSEND_STRIDE_EN
  logic [AW-1:0]  stride_q, stride_d;
  assign stride_c = stride_q;
`else
  assign stride_c = AW'(1);
`endif

  // Lowest set bit of the remaining channel mask.
  assign sel_c   = mask_q & (~mask_q + NCH'(1));
  assign stalled = bus.module_busy && (state_q inside {S_SEL, S_CMP, S_WR});

  // Outputs are computed for the state being entered, so they line up with it once registered.
  always_comb begin
    state_d    = state_q;
    pool_d     = pool_q;
    cnt_max_d  = cnt_max_q;
    wcnt_d     = wcnt_q;
    kcnt_d     = kcnt_q;
    mask_d     = mask_q;
    ctrl_d     = ctrl_q;
    ptr_d      = ptr_q;
    waddr_d    = waddr_q;
    wceb_d     = 1'b1;
    oen_d      = 1'b0;
    cmp_en_d   = 1'b0;
    cmp_sw_d   = 1'b0;
    cmp_mode_d = cmp_mode_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    do_wr      = 1'b0;
    do_cmp     = 1'b0;
    cmp_first  = 1'b0;
`ifdef OSEND_STRIDE_EN
    stride_d   = stride_q;
`endif
    if (!stalled) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.OUTPUT_SEND_POOL || bus.OUTPUT_SEND) begin
            state_d    = S_SEL;
            pool_d     = bus.OUTPUT_SEND_POOL;
            cmp_mode_d = bus.OUTPUT_SEND_POOL & POOL_MAX;
            cnt_max_d  = bus.COUNTER0;
            mask_d     = bus.OUTPUT_EN_CTRL_I;
            ptr_d      = bus.WADDRX_I;
            busy_d     = 1'b1;
`ifdef OSEND_STRIDE_EN
            stride_d   = bus.WSTRIDE_I;
`endif
          end
        end
        S_SEL: begin
          if (mask_q == '0 || cnt_max_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            ctrl_d  = '0;
          end else begin
            ctrl_d = sel_c;
            wcnt_d = '0;
            if (pool_q) begin
              do_cmp    = 1'b1;
              cmp_first = 1'b1;
            end else begin
              do_wr = 1'b1;
            end
          end
        end
        S_CMP: begin
          if (kcnt_q == KW'(POOL_K)) do_wr = 1'b1;
          else                       do_cmp = 1'b1;
        end
        S_WR: begin
          if (wcnt_q == cnt_max_q) begin
            mask_d  = mask_q & ~ctrl_q;
            state_d = S_SEL;
          end else if (pool_q) begin
            do_cmp    = 1'b1;
            cmp_first = 1'b1;
          end else begin
            do_wr = 1'b1;
          end
        end
        S_DONE: begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          cmp_mode_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (do_wr) begin
      state_d = S_WR;
      wceb_d  = 1'b0;
      oen_d   = 1'b1;
      waddr_d = ptr_q;
      ptr_d   = ptr_q + stride_c;
      wcnt_d  = wcnt_d + CW'(1);
    end
    if (do_cmp) begin
      state_d  = S_CMP;
      cmp_en_d = 1'b1;
      cmp_sw_d = cmp_first;
      kcnt_d   = cmp_first ? KW'(1) : kcnt_q + KW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      state_q    <= S_IDLE;
      pool_q     <= 1'b0;
      cnt_max_q  <= '0;
      wcnt_q     <= '0;
      kcnt_q     <= '0;
      mask_q     <= '0;
      ctrl_q     <= '0;
      ptr_q      <= '0;
      waddr_q    <= '0;
      wceb_q     <= 1'b1;
      oen_q      <= 1'b0;
      cmp_en_q   <= 1'b0;
      cmp_mode_q <= 1'b0;
      cmp_sw_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef OSEND_STRIDE_EN
      stride_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pool_q     <= pool_d;
      cnt_max_q  <= cnt_max_d;
      wcnt_q     <= wcnt_d;
      kcnt_q     <= kcnt_d;
      mask_q     <= mask_d;
      ctrl_q     <= ctrl_d;
      ptr_q      <= ptr_d;
      waddr_q    <= waddr_d;
      wceb_q     <= wceb_d;
      oen_q      <= oen_d;
      cmp_en_q   <= cmp_en_d;
      cmp_mode_q <= cmp_mode_d;
      cmp_sw_q   <= cmp_sw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef OSEND_STRIDE_EN
      stride_q   <= stride_d;
`endif
    end
  end

  assign bus.WADDRX           = waddr_q;
  assign bus.WCEBX            = wceb_q;
  assign bus.OUTPUT_EN        = oen_q;
  assign bus.OUTPUT_EN_CTRL   = ctrl_q;
  assign bus.O_COMPARE_EN     = cmp_en_q;
  assign bus.O_COMPARE_MODE   = cmp_mode_q;
  assign bus.O_COMPARE_SWITCH = cmp_sw_q;
  assign bus.OUTPUT_BUSY      = busy_q;
  assign bus.OUTPUT_DONE      = done_q;
endmodule

// File: tb/tb_output_send_seq.sv
// Directed, table-driven bench for output_send_seq (default parameters, POOL_K=4, max pooling).
module tb_output_send_seq;
  logic clk = 1'b0;
  logic rstl;
  always #5 clk = ~clk;

  output_send_seq_if bus ();
  output_send_seq dut (.CLK(clk), .RSTL(rstl), .bus(bus));

  typedef struct packed {
    logic        np;
    logic        pl;
    logic [7:0]  cnt;
    logic [5:0]  mask;
    logic [15:0] base;
    logic [15:0] stride;
    int          stall_at;
    int          restart_at;
    int          nw;
    int          nbusy;
    int          first;
    int          ncmp;
    int          nsw;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // k-th set bit of the mask as a one-hot value.
  function automatic logic [5:0] nth_ch(input logic [5:0] m, input int k);
    int seen = 0;
    nth_ch = '0;
    for (int b = 0; b < 6; b++) begin
      if (m[b]) begin
        if (seen == k) nth_ch = 6'(1) << b;
        seen++;
      end
    end
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int n = 0, nw = 0, ncmp = 0, nsw = 0, ndone = 0, nbusy = 0, first = 0;
    int quiet_bad = 0, en_bad = 0, mode_bad = 0;
    bit done_seen = 0, finished = 0;
    logic [15:0] exp_a;
    logic [5:0]  exp_ch;
    string p = $sformatf("v%0d", idx);
    @(negedge clk);
    bus.COUNTER0         = v.cnt;
    bus.WADDRX_I         = v.base;
    bus.OUTPUT_EN_CTRL_I = v.mask;
`ifdef OSEND_STRIDE_EN
    bus.WSTRIDE_I        = v.stride;
`endif
    bus.OUTPUT_SEND      = v.np;
    bus.OUTPUT_SEND_POOL = v.pl;
    while (!finished && n < 300) begin
      @(negedge clk);
      n++;
      if (done_seen) begin
        check({p, "_busy_after_done"}, 32'(bus.OUTPUT_BUSY), 32'd0);
        check({p, "_ctrl_after_done"}, 32'(bus.OUTPUT_EN_CTRL), 32'd0);
        finished = 1;
      end else begin
        if (bus.OUTPUT_BUSY === 1'b1) nbusy++;
        if (bus.WCEBX === 1'b0) begin
          nw++;
          if (first == 0) first = n;
          exp_a  = v.base + 16'((nw - 1) * int'(v.stride));
          exp_ch = (v.cnt == 0) ? 6'd0 : nth_ch(v.mask, (nw - 1) / int'(v.cnt));
          check($sformatf("%s_addr%0d", p, nw - 1), 32'(bus.WADDRX), 32'(exp_a));
          check($sformatf("%s_ch%0d", p, nw - 1), 32'(bus.OUTPUT_EN_CTRL), 32'(exp_ch));
        end
        if (bus.OUTPUT_EN !== ~bus.WCEBX) en_bad++;
        if (bus.O_COMPARE_EN === 1'b1) ncmp++;
        if (bus.O_COMPARE_SWITCH === 1'b1) begin
          nsw++;
          if (bus.O_COMPARE_EN !== 1'b1) en_bad++;
        end
        if (bus.OUTPUT_BUSY === 1'b1 && bus.O_COMPARE_MODE !== v.pl) mode_bad++;
        if (v.stall_at != 0 && n > v.stall_at && n <= v.stall_at + 5 &&
            (bus.WCEBX === 1'b0 || bus.O_COMPARE_EN === 1'b1)) quiet_bad++;
        if (bus.OUTPUT_DONE === 1'b1) begin
          ndone++;
          done_seen = 1;
          check({p, "_busy_at_done"}, 32'(bus.OUTPUT_BUSY), 32'd1);
        end
      end
      bus.OUTPUT_SEND      = (n == v.restart_at);
      bus.OUTPUT_SEND_POOL = 1'b0;
      bus.module_busy      = (v.stall_at != 0 && n >= v.stall_at && n < v.stall_at + 5);
    end
    bus.OUTPUT_SEND = 1'b0;
    bus.module_busy = 1'b0;
    check({p, "_finished"}, 32'(finished), 32'd1);
    check({p, "_nwrites"}, 32'(nw), 32'(v.nw));
    check({p, "_busy_cycles"}, 32'(nbusy), 32'(v.nbusy));
    check({p, "_done_pulses"}, 32'(ndone), 32'd1);
    check({p, "_first_write"}, 32'(first), 32'(v.first));
    check({p, "_compares"}, 32'(ncmp), 32'(v.ncmp));
    check({p, "_switches"}, 32'(nsw), 32'(v.nsw));
    check({p, "_strobe_consistency"}, 32'(en_bad), 32'd0);
    check({p, "_compare_mode"}, 32'(mode_bad), 32'd0);
    if (v.stall_at != 0) check({p, "_quiet_in_stall"}, 32'(quiet_bad), 32'd0);
    nbusy = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.OUTPUT_BUSY !== 1'b0 || bus.OUTPUT_DONE !== 1'b0) nbusy++;
    end
    check({p, "_idle_after"}, 32'(nbusy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_wcebx"}, 32'(bus.WCEBX), 32'd1);
    check({p, "_output_en"}, 32'(bus.OUTPUT_EN), 32'd0);
    check({p, "_en_ctrl"}, 32'(bus.OUTPUT_EN_CTRL), 32'd0);
    check({p, "_waddrx"}, 32'(bus.WADDRX), 32'd0);
    check({p, "_busy"}, 32'(bus.OUTPUT_BUSY), 32'd0);
    check({p, "_done"}, 32'(bus.OUTPUT_DONE), 32'd0);
    check({p, "_cmp"}, 32'({bus.O_COMPARE_EN, bus.O_COMPARE_MODE, bus.O_COMPARE_SWITCH}), 32'd0);
  endtask

  initial begin
    int k;
    rstl                 = 1'b0;
    bus.OUTPUT_SEND      = 1'b0;
    bus.OUTPUT_SEND_POOL = 1'b0;
    bus.COUNTER0         = '0;
    bus.WADDRX_I         = '0;
    bus.OUTPUT_EN_CTRL_I = '0;
    bus.module_busy      = 1'b0;
`ifdef OSEND_STRIDE_EN
    bus.WSTRIDE_I        = '0;
`endif
    //                 np    pl    cnt   mask   base      strd  stall rst nw busy first cmp sw
    vecs.push_back(vec_t'{1'b1, 1'b0, 8'd3, 6'h05, 16'h0100, 16'd1, 0, 0, 6, 10, 2, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 8'd2, 6'h02, 16'h0200, 16'd1, 0, 0, 2, 13, 6, 8, 2});
    vecs.push_back(vec_t'{1'b1, 1'b0, 8'd0, 6'h05, 16'h0300, 16'd1, 0, 0, 0, 2, 0, 0, 0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 8'd3, 6'h00, 16'h0300, 16'd1, 0, 0, 0, 2, 0, 0, 0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 8'd2, 6'h20, 16'hFFFF, 16'd1, 0, 0, 2, 5, 2, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 8'd1, 6'h21, 16'h0700, 16'd1, 0, 0, 2, 14, 6, 8, 2});
    vecs.push_back(vec_t'{1'b1, 1'b1, 8'd1, 6'h01, 16'h0800, 16'd1, 0, 0, 1, 8, 6, 4, 1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 8'd4, 6'h01, 16'h0400, 16'd1, 3, 0, 4, 12, 2, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 8'd1, 6'h01, 16'h0900, 16'd1, 3, 0, 1, 13, 11, 4, 1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 8'd2, 6'h03, 16'h0500, 16'd1, 0, 2, 4, 8, 2, 0, 0});
`ifdef OSEND_STRIDE_EN
    vecs.push_back(vec_t'{1'b1, 1'b0, 8'd3, 6'h01, 16'h0010, 16'd4, 0, 0, 3, 6, 2, 0, 0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 8'd2, 6'h01, 16'h0020, 16'd0, 0, 0, 2, 5, 2, 0, 0});
`endif

    #12;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rstl = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Asynchronous reset while a write is on the port.
    @(negedge clk);
    bus.COUNTER0         = 8'd5;
    bus.OUTPUT_EN_CTRL_I = 6'h01;
    bus.WADDRX_I         = 16'h0A00;
`ifdef OSEND_STRIDE_EN
    bus.WSTRIDE_I        = 16'd1;
`endif
    bus.OUTPUT_SEND      = 1'b1;
    @(negedge clk);
    bus.OUTPUT_SEND = 1'b0;
    k = 0;
    while (bus.WCEBX !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("midrst_write_seen", 32'(bus.WCEBX), 32'd0);
    #1 rstl = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rstl = 1'b1;
    k = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.OUTPUT_BUSY !== 1'b0 || bus.WCEBX !== 1'b1) k++;
    end
    check("midrst_stays_idle", 32'(k), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
